// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder-tree operand loader.
//   loader_state_e : loader FSM states (FILL collects words, SUM captures the
//                    tree output, HOLD presents the sum until it is taken).
//   sum_width()    : bits needed for an unsigned sum of 2*tree words of
//                    data bits each; wide enough that the sum never wraps.
package adder_tree_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SUM  = 2'd1,
    ST_HOLD = 2'd2
  } loader_state_e;

  function automatic int sum_width(input int tree, input int data);
    return data + $clog2(tree) + 1;
  endfunction

endpackage

// File: rtl/adder_tree2n.sv
// Combinational reduction tree over two packed operand vectors.
// Each lane pair a[i] + b[i] forms a leaf; leaves are then summed pairwise,
// level by level, to a single root.
// Ports:
//   a, b : TREE_SIZE lanes of DATA_SIZE unsigned bits each (lane 0 in LSBs)
//   sum  : zero-extended total of all 2*TREE_SIZE lanes, SUM_W bits
module adder_tree2n #(
  parameter int TREE_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int SUM_W     = 12
) (
  input  logic [TREE_SIZE*DATA_SIZE-1:0] a,
  input  logic [TREE_SIZE*DATA_SIZE-1:0] b,
  output logic [SUM_W-1:0]               sum
);

  // Heap-ordered node storage: node 0 is the root, node i has children
  // 2i+1 and 2i+2, and the last TREE_SIZE entries are the leaves. Kept local
  // to one procedural block so every node is written before it is read.
  always_comb begin : tree
    logic [SUM_W-1:0] node [0:2*TREE_SIZE-2];
    for (int i = 0; i < TREE_SIZE; i++) begin
      node[TREE_SIZE-1+i] = SUM_W'(a[i*DATA_SIZE +: DATA_SIZE])
                          + SUM_W'(b[i*DATA_SIZE +: DATA_SIZE]);
    end
    for (int i = TREE_SIZE-2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    sum = node[0];
  end

endmodule

// File: rtl/adder_tree_loader.sv
// Operand-side driver for adder_tree2n.
// Collects 2*TREE_SIZE unsigned words from a serial stream, packs them into
// the tree's A/B lane registers, registers the tree sum and offers it on an
// output stream.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1 (input side: in_valid & in_ready, output side: out_valid &
// out_ready). in_data is only sampled on such an edge; in_valid while
// in_ready=0 has no effect. out_sum/out_valid stay stable until taken.
//
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   in_data     : operand word, DATA_SIZE bits
//   in_valid    : in_data valid
//   in_ready    : loader can accept a word (registered)
//   out_sum     : registered frame sum, SUM_W bits
//   out_valid   : out_sum valid
//   out_ready   : consumer takes out_sum
//   flush       : present only when ADDER_TREE_LOADER_FLUSH_EN is defined;
//                 closes a partial frame, missing slots count as 0
//
// Build option: ADDER_TREE_LOADER_FLUSH_EN adds the flush port. Without it
// only complete frames produce a sum.
//
// Debug: the FSM state is held in the 'state' variable (loader_state_e).
module adder_tree_loader
  import adder_tree_pkg::*;
#(
  parameter  int TREE_SIZE = 8,
  parameter  int DATA_SIZE = 8,
  localparam int SUM_W     = sum_width(TREE_SIZE, DATA_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [SUM_W-1:0]     out_sum,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef ADDER_TREE_LOADER_FLUSH_EN
  ,
  input  logic                 flush
`endif
);

  localparam int SLOT_W = $clog2(2*TREE_SIZE);
  localparam int LANE_W = SLOT_W - 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(2*TREE_SIZE-1);

  loader_state_e                 state;
  logic [SLOT_W-1:0]             slot;
  logic [TREE_SIZE*DATA_SIZE-1:0] a_reg;
  logic [TREE_SIZE*DATA_SIZE-1:0] b_reg;
  logic [SUM_W-1:0]              tree_sum;

  logic              beat;
  logic              close_frame;
  logic [LANE_W-1:0] lane;

  assign beat = in_valid & in_ready;
  // Slot MSB picks the operand vector, the remaining bits pick the lane.
  assign lane = slot[LANE_W-1:0];

`ifdef ADDER_TREE_LOADER_FLUSH_EN
  // A flush only closes a frame that holds at least one word, counting a
  // word arriving in the same cycle.
  assign close_frame = (beat && (slot == LAST_SLOT))
                     || (flush && (beat || (slot != '0)));
`else
  assign close_frame = beat && (slot == LAST_SLOT);
`endif

  adder_tree2n #(
    .TREE_SIZE (TREE_SIZE),
    .DATA_SIZE (DATA_SIZE),
    .SUM_W     (SUM_W)
  ) u_tree (
    .a   (a_reg),
    .b   (b_reg),
    .sum (tree_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      slot      <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          in_ready <= 1'b1;
          if (beat) begin
            if (slot[SLOT_W-1]) begin
              b_reg[lane*DATA_SIZE +: DATA_SIZE] <= in_data;
            end else begin
              a_reg[lane*DATA_SIZE +: DATA_SIZE] <= in_data;
            end
            slot <= slot + SLOT_W'(1);
          end
          if (close_frame) begin
            slot     <= '0;
            in_ready <= 1'b0;
            state    <= ST_SUM;
          end
        end
        ST_SUM: begin
          // The final word landed on the edge that entered this state, so
          // the tree output is now complete.
          out_sum   <= tree_sum;
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            in_ready  <= 1'b1;
            state     <= ST_FILL;
          end
        end
        default: begin
          state    <= ST_FILL;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_loader.sv
// Directed bench for adder_tree_loader (TREE_SIZE=8, DATA_SIZE=8).
// A frame-level model (queue of accepted words, summed when the frame closes)
// predicts in_ready/out_valid/out_sum every cycle; hand-computed sums in
// exp_q pin each delivered result.
module tb_adder_tree_loader;

  localparam int TS = 8;
  localparam int DS = 8;
  localparam int SW = DS + $clog2(TS) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic [DS-1:0] in_data   = '0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic          flush     = 1'b0;
  logic          in_ready;
  logic [SW-1:0] out_sum;
  logic          out_valid;

  always #5 clk = ~clk;

  adder_tree_loader #(.TREE_SIZE(TS), .DATA_SIZE(DS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef ADDER_TREE_LOADER_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // phase 0: collecting words, 1: frame closed, sum appears next edge,
  // 2: sum offered until taken.
  int          m_phase = 0;
  bit          m_ready = 1'b0;
  bit          m_ov    = 1'b0;
  logic [SW-1:0] m_sum = '0;
  int unsigned frame_q[$];
  bit          closing;
  int          acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_ready = 1'b0;
      m_ov    = 1'b0;
      m_sum   = '0;
      frame_q.delete();
    end else begin
      case (m_phase)
        0: begin
          closing = 1'b0;
          if (in_valid && m_ready) begin
            frame_q.push_back(int'(in_data));
            if (frame_q.size() == 2*TS) closing = 1'b1;
          end
`ifdef ADDER_TREE_LOADER_FLUSH_EN
          if (flush && frame_q.size() > 0) closing = 1'b1;
`endif
          m_ready = !closing;
          if (closing) m_phase = 1;
        end
        1: begin
          acc = 0;
          foreach (frame_q[i]) acc += frame_q[i];
          m_sum = SW'(acc);
          frame_q.delete();
          m_ov    = 1'b1;
          m_phase = 2;
        end
        default: begin
          if (out_ready) begin
            m_ov    = 1'b0;
            m_ready = 1'b1;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("in_ready", 32'(in_ready), 32'(m_ready));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov || !rst_n) check("out_sum", 32'(out_sum), 32'(m_sum));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out_beat", 32'(out_sum), 32'hFFFF_FFFF);
        else check("literal_sum", 32'(out_sum), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DS-1:0] d, input logic f);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_fill(input logic [DS-1:0] d, input int n);
    for (int i = 0; i < n; i++) send(d, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    chk_on = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Words 1..16, continuous valid
    exp_q.push_back(SW'(136));
    for (int i = 1; i <= 16; i++) send(DS'(i), 1'b0);
    idle(4);
    check("model_sum_136", 32'(m_sum), 32'd136);

    // All 255: maximum sum
    exp_q.push_back(SW'(4080));
    send_fill(8'd255, 16);
    idle(4);
    check("model_sum_4080", 32'(m_sum), 32'd4080);

    // Back-pressure: sum held, in_valid during hold ignored
    out_ready = 1'b0;
    exp_q.push_back(SW'(136));
    for (int i = 1; i <= 16; i++) send(DS'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    repeat (7) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    exp_q.push_back(SW'(32));
    send_fill(8'd2, 16);
    idle(4);
    check("model_sum_32", 32'(m_sum), 32'd32);

    // Gapped input: 7, 5, then fourteen zeros
    exp_q.push_back(SW'(12));
    send(8'd7, 1'b0); idle(1);
    send(8'd5, 1'b0); idle(1);
    for (int i = 0; i < 14; i++) begin
      send(8'd0, 1'b0);
      idle(1);
    end
    idle(4);
    check("model_sum_12", 32'(m_sum), 32'd12);

    // Reset mid-frame discards partial words
    exp_q.push_back(SW'(48));
    send_fill(8'd5, 6);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    send_fill(8'd3, 16);
    idle(4);
    check("model_sum_48", 32'(m_sum), 32'd48);

`ifdef ADDER_TREE_LOADER_FLUSH_EN
    // Partial frame closed by flush on the third beat
    exp_q.push_back(SW'(178));
    exp_q.push_back(SW'(16));
    send(8'd123, 1'b0);
    send(8'd45, 1'b0);
    send(8'd10, 1'b1);
    idle(4);
    check("model_sum_178", 32'(m_sum), 32'd178);
    send_fill(8'd1, 16);
    idle(4);
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
